// File: rtl/radix4_mac.sv
// radix4_mac: sequential radix-4 multiply-accumulate, P = Q*D + R, one quotient digit per cycle.
// Optional RADIX4_MAC_CHECK_EN adds N input and registered match/mismatch outputs.
module radix4_mac #(
    parameter int QW = 10,
    parameter int DW = 6,
    parameter int RW = 8,
    parameter int PW = QW + DW + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [QW-1:0]     Q,
    input  logic [DW-1:0]     D,
    input  logic [RW-1:0]     R,
`ifdef RADIX4_MAC_CHECK_EN
    input  logic [QW+DW-1:0]  N,
    output logic              match,
    output logic              mismatch,
`endif
    output logic [PW-1:0]     P,
    output logic              busy,
    output logic              done
);
    localparam int NDIG = QW / 2;
    localparam int CW = $clog2(NDIG + 1);

    typedef enum logic [1:0] {IDLE, MUL, ADDR} state_t;

    state_t state, state_next;
    logic [QW-1:0] qreg;
    logic [DW-1:0] dreg;
    logic [RW-1:0] rreg;
    logic [PW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [PW-1:0] d1, d2, d3, pp, sum;
    logic [1:0]    digit;
    logic          last;
`ifdef RADIX4_MAC_CHECK_EN
    logic [QW+DW-1:0] nreg;
`endif

    // Partial product picked from 0, D, 2D, 3D; no negative digits.
    assign digit = qreg[QW-1:QW-2];
    assign d1    = PW'(dreg);
    assign d2    = d1 << 1;
    assign d3    = d2 + d1;
    assign pp    = digit[1] ? (digit[0] ? d3 : d2) : (digit[0] ? d1 : '0);
    assign sum   = acc + PW'(rreg);
    assign last  = cnt == CW'(NDIG - 1);

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? MUL : IDLE;
            MUL:     state_next = last ? ADDR : MUL;
            ADDR:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            qreg <= '0;
            dreg <= '0;
            rreg <= '0;
            acc  <= '0;
            cnt  <= '0;
            P    <= '0;
            busy <= 1'b0;
            done <= 1'b0;
`ifdef RADIX4_MAC_CHECK_EN
            nreg     <= '0;
            match    <= 1'b0;
            mismatch <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    qreg <= Q;
                    dreg <= D;
                    rreg <= R;
                    acc  <= '0;
                    cnt  <= '0;
                    busy <= 1'b1;
`ifdef RADIX4_MAC_CHECK_EN
                    nreg     <= N;
                    match    <= 1'b0;
                    mismatch <= 1'b0;
`endif
                end
                MUL: begin
                    acc  <= (acc << 2) + pp;
                    qreg <= qreg << 2;
                    cnt  <= cnt + 1'b1;
                end
                ADDR: begin
                    P    <= sum;
                    busy <= 1'b0;
                    done <= 1'b1;
`ifdef RADIX4_MAC_CHECK_EN
                    match    <= sum == PW'(nreg);
                    mismatch <= sum != PW'(nreg);
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_radix4_mac.sv
// tb_radix4_mac: vector-table and directed-sequence bench for radix4_mac.
module tb_radix4_mac;
    localparam int QW = 10, DW = 6, RW = 8, PW = QW + DW + 1, NV = 24;

    logic clk = 1'b0, resetn = 1'b0, start = 1'b0;
    logic [QW-1:0] Q = '0;
    logic [DW-1:0] D = '0;
    logic [RW-1:0] R = '0;
    logic [PW-1:0] P;
    logic busy, done;
`ifdef RADIX4_MAC_CHECK_EN
    logic [QW+DW-1:0] N = '0;
    logic match, mismatch;
`endif

    int n_checks = 0, n_fail = 0;

    radix4_mac dut (
        .clk(clk), .resetn(resetn), .start(start), .Q(Q), .D(D), .R(R),
`ifdef RADIX4_MAC_CHECK_EN
        .N(N), .match(match), .mismatch(mismatch),
`endif
        .P(P), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [QW-1:0]    q;
        logic [DW-1:0]    d;
        logic [RW-1:0]    r;
        logic [QW+DW-1:0] n;
        logic [PW-1:0]    p;
    } vec_t;

    vec_t tbl [NV];

    function automatic logic [PW-1:0] model(input logic [QW-1:0] q, input logic [DW-1:0] d, input logic [RW-1:0] r);
        longint v;
        v = longint'(q) * longint'(d) + longint'(r);
        return v[PW-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic [QW-1:0] q, input logic [DW-1:0] d, input logic [RW-1:0] r, input logic [QW+DW-1:0] n);
        Q = q; D = d; R = r; start = 1'b1;
`ifdef RADIX4_MAC_CHECK_EN
        N = n;
`else
        if (n != n) $display("unreachable");
`endif
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt, output bit p_moved);
        logic [PW-1:0] p0;
        p0 = P; lat = 0; bcnt = 0; p_moved = 1'b0;
        while (!done && lat < 20) begin
            bcnt += int'(busy);
            if (P !== p0) p_moved = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt, dcnt;
        bit moved;
        tbl[0] = '{10'd163, 6'd21, 8'd5, 16'd3428, 17'd3428};
        tbl[1] = '{10'd1023, 6'd63, 8'd255, 16'd64704, 17'd64704};
        tbl[2] = '{10'd163, 6'd21, 8'd5, 16'd3427, 17'd3428};
        tbl[3] = '{10'd0, 6'd37, 8'd200, 16'd200, 17'd200};
        tbl[4] = '{10'd0, 6'd0, 8'd0, 16'd0, 17'd0};
        for (int i = 5; i < NV; i++) begin
            tbl[i].q = QW'($urandom_range(1023, 0));
            tbl[i].d = DW'($urandom_range(63, 0));
            tbl[i].r = RW'($urandom_range(255, 0));
            tbl[i].p = model(tbl[i].q, tbl[i].d, tbl[i].r);
            tbl[i].n = (i % 2 == 0) ? tbl[i].p[QW+DW-1:0] : tbl[i].p[QW+DW-1:0] ^ 16'd1;
        end

        repeat (3) @(negedge clk);
        check("reset_p", P, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
`ifdef RADIX4_MAC_CHECK_EN
        check("reset_match", match, 0);
        check("reset_mismatch", mismatch, 0);
`endif
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            issue(tbl[i].q, tbl[i].d, tbl[i].r, tbl[i].n);
            wait_done(lat, bcnt, moved);
            check($sformatf("v%0d_latency", i), lat, 6);
            check($sformatf("v%0d_busy_cycles", i), bcnt, 6);
            check($sformatf("v%0d_p_stable", i), moved, 0);
            check($sformatf("v%0d_p", i), P, tbl[i].p);
            @(negedge clk);
            check($sformatf("v%0d_done_drop", i), done, 0);
            check($sformatf("v%0d_p_hold", i), P, tbl[i].p);
`ifdef RADIX4_MAC_CHECK_EN
            check($sformatf("v%0d_match", i), match, tbl[i].p == PW'(tbl[i].n));
            check($sformatf("v%0d_mismatch", i), mismatch, tbl[i].p != PW'(tbl[i].n));
`endif
        end

        // Back-to-back: second start in the done cycle.
        issue(10'd0, 6'd37, 8'd200, 16'd200);
        wait_done(lat, bcnt, moved);
        check("b2b_first_p", P, 200);
        issue(10'd5, 6'd0, 8'd0, 16'd0);
        wait_done(lat, bcnt, moved);
        check("b2b_second_latency", lat, 6);
        check("b2b_second_p", P, 0);
        @(negedge clk);

        // Start re-pulsed while busy must be ignored.
        issue(10'd163, 6'd21, 8'd5, 16'd3428);
        @(negedge clk);
        Q = 10'd1; D = 6'd1; R = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        repeat (15) begin
            dcnt += int'(done);
            @(negedge clk);
        end
        check("ignored_start_dones", dcnt, 1);
        check("ignored_start_p", P, 3428);

        // Reset mid-computation discards the result.
        issue(10'd1023, 6'd63, 8'd255, 16'd64704);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("midreset_p", P, 0);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        dcnt = 0;
        repeat (10) begin
            @(negedge clk);
            dcnt += int'(done);
        end
        check("midreset_no_done", dcnt, 0);
        issue(10'd163, 6'd21, 8'd5, 16'd3428);
        wait_done(lat, bcnt, moved);
        check("after_reset_latency", lat, 6);
        check("after_reset_p", P, 3428);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule
